// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl
//   Multi-cycle wide adder/subtractor. A single 16-bit slice adder (add16pg)
//   is reused over NSLICE cycles, least-significant slice first, with the
//   slice carry chained through a register. The result, carry-out and
//   signed-overflow flag are registered and change only when the last slice
//   completes.
//
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous active-high reset
//     start in   request, sampled when busy=0 (IDLE or DONE)
//     sub   in   0: s = a + b + cin, 1: s = a - b (cin ignored)
//     a, b  in   WIDTH-bit operands, sampled at the accepting edge
//     cin   in   carry-in for add, sampled at the accepting edge
//     busy  out  operation in progress
//     done  out  one-cycle pulse, s/cout/ovf hold the new result
//     s     out  WIDTH-bit result register
//     cout  out  carry out of the MSB (1 = no borrow for sub)
//     ovf   out  two's-complement overflow of the result

// 16-bit slice adder with group propagate/generate outputs.
// Slice carry-out for a given carry-in is gg_o | (pg_o & ci_i).
module add16pg (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        ci_i,
  output logic [15:0] s_o,
  output logic        pg_o,
  output logic        gg_o
);
  logic [16:0] raw;

  // Generate is the carry the slice produces on its own (carry-in 0);
  // propagate means every bit position passes an incoming carry through.
  assign raw  = {1'b0, a_i} + {1'b0, b_i};
  assign gg_o = raw[16];
  assign pg_o = &(a_i ^ b_i);
  assign s_o  = a_i + b_i + {15'd0, ci_i};
endmodule

module add_seq_ctrl #(
  parameter int NSLICE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [16*NSLICE-1:0] a,
  input  logic [16*NSLICE-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [16*NSLICE-1:0] s,
  output logic                 cout,
  output logic                 ovf
);
  localparam int WIDTH = 16 * NSLICE;
  localparam int IDXW  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               carry_q, carry_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [15:0]        sl_a, sl_b, sl_s;
  logic               sl_pg, sl_gg, sl_co;
  logic [WIDTH-1:0]   part_new;
  logic               last;

  // Select the active slice of the working operands.
  always_comb begin
    sl_a = 16'd0;
    sl_b = 16'd0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx_q == IDXW'(k)) begin
        sl_a = opa_q[16*k +: 16];
        sl_b = opb_q[16*k +: 16];
      end
    end
  end

  add16pg u_slice (
    .a_i  (sl_a),
    .b_i  (sl_b),
    .ci_i (carry_q),
    .s_o  (sl_s),
    .pg_o (sl_pg),
    .gg_o (sl_gg)
  );

  assign sl_co = sl_gg | (sl_pg & carry_q);
  assign last  = (idx_q == IDXW'(NSLICE - 1));

  // Partial sum with the current slice merged in; on the last slice this is
  // the complete result.
  always_comb begin
    part_new = part_q;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx_q == IDXW'(k)) begin
        part_new[16*k +: 16] = sl_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    part_d  = part_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          // Subtraction is a + ~b + 1, so invert B and force the carry-in.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        busy    = 1'b1;
        part_d  = part_new;
        carry_d = sl_co;
        if (last) begin
          idx_d   = '0;
          s_d     = part_new;
          cout_d  = sl_co;
          // Overflow = carry out of MSB xor carry into MSB.
          ovf_d   = sl_co ^ (sl_a[15] ^ sl_b[15] ^ sl_s[15]);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      idx_q   <= '0;
      part_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand registers are only meaningful after an accept, so they carry
  // no reset.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
module tb_add_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic        cin;
  logic [63:0] a, b;
  int          sel;
  int          n_checks = 0;
  int          n_pass   = 0;

  logic        start1, start2, start4;
  logic        busy1, busy2, busy4, done1, done2, done4;
  logic        cout1, cout2, cout4, ovf1, ovf2, ovf4;
  logic [15:0] s1;
  logic [31:0] s2;
  logic [63:0] s4;

  logic        d_busy, d_done, d_cout, d_ovf;
  logic [63:0] d_s;

  always #5 clk = ~clk;

  assign start1 = start && (sel == 1);
  assign start2 = start && (sel == 2);
  assign start4 = start && (sel == 4);

  add_seq_ctrl #(.NSLICE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));
  add_seq_ctrl #(.NSLICE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub), .a(a[31:0]), .b(b[31:0]),
    .cin(cin), .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2));
  add_seq_ctrl #(.NSLICE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4));

  assign d_busy = (sel == 1) ? busy1 : (sel == 2) ? busy2 : busy4;
  assign d_done = (sel == 1) ? done1 : (sel == 2) ? done2 : done4;
  assign d_cout = (sel == 1) ? cout1 : (sel == 2) ? cout2 : cout4;
  assign d_ovf  = (sel == 1) ? ovf1  : (sel == 2) ? ovf2  : ovf4;
  assign d_s    = (sel == 1) ? {48'd0, s1} : (sel == 2) ? {32'd0, s2} : s4;

  // Reference: integer add/subtract at width w with mathematical signed
  // range test for overflow and unsigned compare for borrow.
  function automatic void model(input int w, input logic [63:0] ma, mb,
                                input logic mcin, msub,
                                output logic [63:0] es, output logic ec,
                                output logic eo);
    logic [65:0]        tot;
    logic signed [65:0] sa, sb, ss, lim;
    logic [63:0]        mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ma = ma & mask;
    mb = mb & mask;
    sa = $signed({2'b00, ma});
    sb = $signed({2'b00, mb});
    if (ma[w-1]) sa = sa - (66'sd1 <<< w);
    if (mb[w-1]) sb = sb - (66'sd1 <<< w);
    lim = 66'sd1 <<< (w - 1);
    if (msub) begin
      tot = {2'b00, ma} - {2'b00, mb};
      ec  = (ma >= mb);
      ss  = sa - sb;
    end else begin
      tot = {2'b00, ma} + {2'b00, mb} + {65'd0, mcin};
      ec  = tot[w];
      ss  = sa + sb + $signed({65'd0, mcin});
    end
    es = tot[63:0] & mask;
    eo = (ss >= lim) || (ss < -lim);
  endfunction

  // Launch one op on the selected DUT and wait (bounded) for done.
  // Inputs are scrambled right after the accepting edge.
  task automatic do_op(input logic [63:0] ia, ib, input logic icin, isub,
                       output int lat);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!d_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0; sel = 2;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (d_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", d_busy); else n_pass++;
    n_checks++; if (d_done !== 1'b0) $display("FAIL reset_done got %b exp 0", d_done); else n_pass++;
    n_checks++; if (d_s !== 64'd0) $display("FAIL reset_s got %h exp 0", d_s); else n_pass++;
    n_checks++; if (d_cout !== 1'b0) $display("FAIL reset_cout got %b exp 0", d_cout); else n_pass++;
    n_checks++; if (d_ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", d_ovf); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_carry();
    int lat, nbusy;
    sel = 2;
    a = 64'h0000FFFF; b = 64'h1; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; nbusy = 0;
    while (!d_done && lat < 20) begin
      if (d_busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat !== 2) $display("FAIL carry_latency got %0d exp 2", lat); else n_pass++;
    n_checks++; if (nbusy !== 2) $display("FAIL carry_busy_cycles got %0d exp 2", nbusy); else n_pass++;
    n_checks++; if (d_s !== 64'h00010000 || d_cout !== 1'b0 || d_ovf !== 1'b0)
      $display("FAIL carry_result got s=%h c=%b v=%b exp s=00010000 c=0 v=0", d_s, d_cout, d_ovf);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (d_done !== 1'b0 || d_busy !== 1'b0)
      $display("FAIL carry_done_pulse got done=%b busy=%b exp 0 0", d_done, d_busy);
    else n_pass++;
  endtask

  task automatic test_wrap_ovf();
    int lat;
    sel = 2;
    do_op(64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 2 || d_s !== 64'h0 || d_cout !== 1'b1 || d_ovf !== 1'b0)
      $display("FAIL wrap got lat=%0d s=%h c=%b v=%b exp 2 0 1 0", lat, d_s, d_cout, d_ovf);
    else n_pass++;
    do_op(64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 2 || d_s !== 64'h80000000 || d_cout !== 1'b0 || d_ovf !== 1'b1)
      $display("FAIL sovf got lat=%0d s=%h c=%b v=%b exp 2 80000000 0 1", lat, d_s, d_cout, d_ovf);
    else n_pass++;
  endtask

  task automatic test_sub();
    int lat;
    sel = 2;
    do_op(64'h5, 64'h7, 1'b1, 1'b1, lat);
    n_checks++; if (lat !== 2 || d_s !== 64'hFFFFFFFE || d_cout !== 1'b0 || d_ovf !== 1'b0)
      $display("FAIL sub_neg got lat=%0d s=%h c=%b v=%b exp 2 fffffffe 0 0", lat, d_s, d_cout, d_ovf);
    else n_pass++;
    do_op(64'h80000000, 64'h1, 1'b0, 1'b1, lat);
    n_checks++; if (lat !== 2 || d_s !== 64'h7FFFFFFF || d_cout !== 1'b1 || d_ovf !== 1'b1)
      $display("FAIL sub_ovf got lat=%0d s=%h c=%b v=%b exp 2 7fffffff 1 1", lat, d_s, d_cout, d_ovf);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    sel = 2;
    a = 64'h1; b = 64'h2; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    // start stays high through both RUN cycles with other operands
    a = 64'h100; b = 64'h200;
    n_checks++; if (d_s !== 64'h7FFFFFFF) $display("FAIL hold_s_run1 got %h exp 7fffffff", d_s); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (d_s !== 64'h7FFFFFFF || d_busy !== 1'b1)
      $display("FAIL hold_s_run2 got s=%h busy=%b exp 7fffffff 1", d_s, d_busy);
    else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (d_done !== 1'b1 || d_s !== 64'h3)
      $display("FAIL ignore_result got done=%b s=%h exp 1 3", d_done, d_s);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (d_busy !== 1'b0 || d_done !== 1'b0 || d_s !== 64'h3)
      $display("FAIL ignore_queued got busy=%b done=%b s=%h exp 0 0 3", d_busy, d_done, d_s);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    sel = 2;
    a = 64'h10; b = 64'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (d_done !== 1'b1 || d_s !== 64'h30)
      $display("FAIL b2b_first got done=%b s=%h exp 1 30", d_done, d_s);
    else n_pass++;
    a = 64'h100; b = 64'h5;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (d_busy !== 1'b1 || d_done !== 1'b0 || d_s !== 64'h30)
      $display("FAIL b2b_accept got busy=%b done=%b s=%h exp 1 0 30", d_busy, d_done, d_s);
    else n_pass++;
    lat = 0;
    while (!d_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat !== 2 || d_s !== 64'h105)
      $display("FAIL b2b_second got lat=%0d s=%h exp 2 105", lat, d_s);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen_done;
    sel = 2;
    a = 64'hAAAA; b = 64'h1; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++; if (d_busy !== 1'b0 || d_done !== 1'b0 || d_s !== 64'h0 || d_cout !== 1'b0 || d_ovf !== 1'b0)
      $display("FAIL midreset_outputs got busy=%b done=%b s=%h c=%b v=%b exp all 0",
               d_busy, d_done, d_s, d_cout, d_ovf);
    else n_pass++;
    seen_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (d_done) seen_done = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (d_done) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) $display("FAIL midreset_no_done got %b exp 0", seen_done); else n_pass++;
    do_op(64'h1234, 64'h1111, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 2 || d_s !== 64'h2345)
      $display("FAIL midreset_fresh got lat=%0d s=%h exp 2 2345", lat, d_s);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int n, input int count);
    int          lat;
    logic [63:0] ra, rb, es;
    logic        rc, rs, ec, eo;
    int          errs;
    sel = n;
    errs = 0;
    for (int i = 0; i < count; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      // bias towards carry/overflow corner operands
      if (($urandom % 8) == 0) ra = {ra[63], {63{~ra[63]}}};
      if (($urandom % 8) == 0) rb = 64'h1;
      rc = 1'($urandom);
      rs = 1'($urandom);
      do_op(ra, rb, rc, rs, lat);
      model(16 * n, ra, rb, rc, rs, es, ec, eo);
      n_checks++;
      if (lat !== n || d_s !== es || d_cout !== ec || d_ovf !== eo) begin
        if (errs < 10)
          $display("FAIL random_n%0d a=%h b=%h cin=%b sub=%b got lat=%0d s=%h c=%b v=%b exp lat=%0d s=%h c=%b v=%b",
                   n, ra, rb, rc, rs, lat, d_s, d_cout, d_ovf, n, es, ec, eo);
        errs++;
      end else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_carry();
    test_wrap_ovf();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random(1, 3000);
    test_random(2, 3000);
    test_random(4, 3000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
